// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster, sync and strobe bundle between the timing generator and its consumers
interface video_timing_gen_if;
    logic        en;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic        hsync_d;
    logic        vsync_d;
    logic        de_d;
    logic [15:0] frame_cnt;

    modport master (
        input  en,
        output sx, sy, hsync, vsync, de, line_start, frame_start,
        output hsync_d, vsync_d, de_d, frame_cnt
    );

    modport slave (
        output en,
        input  sx, sy, hsync, vsync, de, line_start, frame_start,
        input  hsync_d, vsync_d, de_d, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel-clock raster timing generator with delayed sync copies; VTG_FRAME_CNT_EN builds the frame counter
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vif
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // {hsync, vsync, de} while blanked and out of sync
    localparam logic [2:0]  SIG_IDLE = {~H_POL, ~V_POL, 1'b0};

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (PIPE_DLY > 15) begin : g_bad_dly
            $error("video_timing_gen: PIPE_DLY must be 0..15");
        end
    endgenerate

    logic [9:0] sx_q, sx_d;
    logic [9:0] sy_q, sy_d;
    logic       vis_q, vis_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    // Sync and blanking decode the next counter values so they register
    // together with the coordinates they describe.
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (vif.en) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
            end else begin
                sx_d = sx_q + 10'd1;
            end
            ls_d = (sx_d == '0);
            fs_d = (sx_d == '0) && (sy_d == '0);
        end
        vis_d = (32'(sx_d) < H_ACTIVE) && (32'(sy_d) < V_ACTIVE);
        hs_d  = ((32'(sx_d) >= HS_START) && (32'(sx_d) < HS_END)) ? H_POL : ~H_POL;
        vs_d  = ((32'(sy_d) >= VS_START) && (32'(sy_d) < VS_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q  <= H_LAST;
            sy_q  <= V_LAST;
            vis_q <= 1'b0;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            vis_q <= vis_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign vif.sx          = sx_q;
    assign vif.sy          = sy_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.de          = vis_q;
    assign vif.line_start  = ls_q;
    assign vif.frame_start = fs_q;

    // Delay line runs every clock regardless of en so the encoders stay
    // aligned with the shader pipeline, which never stalls.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign vif.hsync_d = hs_q;
            assign vif.vsync_d = vs_q;
            assign vif.de_d    = vis_q;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_DLY];
            logic [2:0] dly_d [PIPE_DLY];

            always_comb begin
                dly_d[0] = {hs_q, vs_q, vis_q};
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(PIPE_DLY); i++) begin
                        dly_q[i] <= SIG_IDLE;
                    end
                end else begin
                    for (int i = 0; i < int'(PIPE_DLY); i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign {vif.hsync_d, vif.vsync_d, vif.de_d} = dly_q[PIPE_DLY-1];
        end
    endgenerate

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q + {15'd0, fs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign vif.frame_cnt = fcnt_q;
`else
    assign vif.frame_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen (default 640x480 and a small raster)
module tb_video_timing_gen;
`ifdef VTG_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;

    video_timing_gen_if ifa ();
    video_timing_gen_if ifb ();

    video_timing_gen #(.PIPE_DLY(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vif   (ifa.master)
    );

    // 16 x 11 raster: hsync high (H_POL=1) at sx 10..12, vsync low at sy 7..8
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b0), .PIPE_DLY(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vif   (ifb.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference raster model, index 0 = dut_a, 1 = dut_b
    int         mx [2];
    int         my [2];
    bit [2:0]   cur [2];
    bit [2:0]   p1 [2];
    bit [2:0]   p2 [2];
    bit         mls [2];
    bit         mfs [2];
    bit [15:0]  mfc [2];
    int         merr [2];

    function automatic bit [2:0] model_sig(input int k, input int x, input int y);
        int ha, hss, hse, va, vss, vse;
        bit hp;
        if (k == 0) begin
            ha = 640; hss = 656; hse = 752; va = 480; vss = 490; vse = 492; hp = 1'b0;
        end else begin
            ha = 8;   hss = 10;  hse = 13;  va = 6;   vss = 7;   vse = 9;   hp = 1'b1;
        end
        model_sig[2] = (x >= hss && x < hse) ? hp : ~hp;
        model_sig[1] = (y >= vss && y < vse) ? 1'b0 : 1'b1;
        model_sig[0] = (x < ha) && (y < va);
    endfunction

    task automatic model_reset(input int k);
        mx[k]  = (k == 0) ? 799 : 15;
        my[k]  = (k == 0) ? 524 : 10;
        cur[k] = (k == 0) ? 3'b110 : 3'b010;
        p1[k]  = cur[k];
        p2[k]  = cur[k];
        mls[k] = 1'b0;
        mfs[k] = 1'b0;
        mfc[k] = 16'd0;
    endtask

    task automatic compare();
        logic [43:0] obs, exp;
        bit [2:0]    d;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? p2[k] : cur[k];
            exp = {mfc[k], 10'(mx[k]), 10'(my[k]), cur[k], mls[k], mfs[k], d};
            if (k == 0)
                obs = {ifa.frame_cnt, ifa.sx, ifa.sy, ifa.hsync, ifa.vsync, ifa.de,
                       ifa.line_start, ifa.frame_start, ifa.hsync_d, ifa.vsync_d, ifa.de_d};
            else
                obs = {ifb.frame_cnt, ifb.sx, ifb.sy, ifb.hsync, ifb.vsync, ifb.de,
                       ifb.line_start, ifb.frame_start, ifb.hsync_d, ifb.vsync_d, ifb.de_d};
            if (obs !== exp) merr[k]++;
        end
    endtask

    task automatic step();
        bit r [2];
        bit e [2];
        r[0] = rst_n_a; r[1] = rst_n_b;
        e[0] = ifa.en;  e[1] = ifb.en;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!r[k]) begin
                model_reset(k);
            end else begin
                p2[k] = p1[k];
                p1[k] = cur[k];
                if (FC_EN && mfs[k]) mfc[k] = mfc[k] + 16'd1;
                mls[k] = 1'b0;
                mfs[k] = 1'b0;
                if (e[k]) begin
                    if (mx[k] == ((k == 0) ? 799 : 15)) begin
                        mx[k] = 0;
                        my[k] = (my[k] == ((k == 0) ? 524 : 10)) ? 0 : my[k] + 1;
                    end else begin
                        mx[k]++;
                    end
                    mls[k] = (mx[k] == 0);
                    mfs[k] = (mx[k] == 0) && (my[k] == 0);
                end
                cur[k] = model_sig(k, mx[k], my[k]);
            end
        end
        compare();
    endtask

    task automatic run_to(input int k, input int x, input int y, input int limit);
        int n;
        n = 0;
        while (!(mx[k] == x && my[k] == y) && n < limit) begin
            step();
            n++;
        end
        check($sformatf("reach_%0d_%0d_%0d", k, x, y), (mx[k] == x && my[k] == y), 1);
    endtask

    int hs_cnt, hs_first, hs_last, ls_cnt, ls_at;
    int vs_cnt, hb_cnt, hb_first, fs_cnt, fs_last, fs_gap, hold_err;

    initial begin
        merr[0] = 0; merr[1] = 0;
        ifa.en = 1'b1; ifb.en = 1'b1;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        model_reset(0); model_reset(1);
        step(); step();

        check("a_rst_sx", ifa.sx, 799);
        check("a_rst_sy", ifa.sy, 524);
        check("a_rst_de", ifa.de, 0);
        check("a_rst_hsync", ifa.hsync, 1);
        check("a_rst_vsync", ifa.vsync, 1);
        check("a_rst_strobes", {ifa.line_start, ifa.frame_start}, 0);
        check("a_rst_dly", {ifa.hsync_d, ifa.vsync_d, ifa.de_d}, 3'b110);
        check("a_rst_fcnt", ifa.frame_cnt, 0);
        check("b_rst_hsync", ifb.hsync, 0);
        check("b_rst_pos", {ifb.sx, ifb.sy}, {10'd15, 10'd10});

        // First enabled clock after release lands on (0,0)
        rst_n_a = 1'b1;
        step();
        check("a_first_pos", {ifa.sx, ifa.sy}, 20'd0);
        check("a_first_de", ifa.de, 1);
        check("a_first_ls", ifa.line_start, 1);
        check("a_first_fs", ifa.frame_start, 1);

        hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; ls_at = -1;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (i < 800 && ifa.hsync == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = ifa.sx;
                hs_last = ifa.sx;
            end
            if (ifa.line_start) begin
                ls_cnt++;
                ls_at = i;
            end
            if (ifa.sx == 10'd639) check("a_de_639", ifa.de, 1);
            if (ifa.sx == 10'd640) check("a_de_640", ifa.de, 0);
            if (ifa.sx == 10'd657) check("a_hsd_657", ifa.hsync_d, 1);
            if (ifa.sx == 10'd658) check("a_hsd_658", ifa.hsync_d, 0);
            if (ifa.sx == 10'd753) check("a_hsd_753", ifa.hsync_d, 0);
            if (ifa.sx == 10'd754) check("a_hsd_754", ifa.hsync_d, 1);
            if (ifa.sx == 10'd2 && ifa.sy == 10'd0) check("a_ded_2", ifa.de_d, 1);
        end
        check("a_hs_width", hs_cnt, 96);
        check("a_hs_first", hs_first, 656);
        check("a_hs_last", hs_last, 751);
        check("a_ls_count", ls_cnt, 1);
        check("a_ls_period", ls_at, 800);
        check("a_line1", ifa.sy, 1);

        // Mid-frame reset: outputs and delay line return to idle at once
        run_to(0, 300, 100, 90000);
        check("a_pre_rst_ded", ifa.de_d, 1);
        rst_n_a = 1'b0;
        #1;
        model_reset(0);
        compare();
        check("a_mid_rst_pos", {ifa.sx, ifa.sy}, {10'd799, 10'd524});
        check("a_mid_rst_sig", {ifa.hsync, ifa.vsync, ifa.de}, 3'b110);
        check("a_mid_rst_dly", {ifa.hsync_d, ifa.vsync_d, ifa.de_d}, 3'b110);
        step();
        rst_n_a = 1'b1;
        step();
        check("a_restart_pos", {ifa.sx, ifa.sy}, 20'd0);
        check("a_restart_fs", ifa.frame_start, 1);

        // Small raster: two frames free run
        rst_n_b = 1'b1;
        step();
        check("b_first_pos", {ifb.sx, ifb.sy}, 20'd0);
        check("b_first_fs", ifb.frame_start, 1);
        vs_cnt = (ifb.vsync == 1'b0) ? 1 : 0;
        hb_cnt = 0; hb_first = -1; fs_cnt = 1; fs_last = 0; fs_gap = -1;
        for (int i = 1; i <= 352; i++) begin
            step();
            if (i < 352 && ifb.vsync == 1'b0) vs_cnt++;
            if (i < 16 && ifb.hsync == 1'b1) begin
                hb_cnt++;
                if (hb_first < 0) hb_first = ifb.sx;
            end
            if (ifb.frame_start) begin
                fs_cnt++;
                fs_gap = i - fs_last;
                fs_last = i;
            end
            if (i == 1)   check("b_fcnt_1", ifb.frame_cnt, FC_EN ? 1 : 0);
            if (i == 176) check("b_fcnt_pulse", ifb.frame_cnt, FC_EN ? 1 : 0);
            if (i == 177) check("b_fcnt_2", ifb.frame_cnt, FC_EN ? 2 : 0);
        end
        check("b_vs_width", vs_cnt, 64);
        check("b_hs_width", hb_cnt, 3);
        check("b_hs_first", hb_first, 10);
        check("b_fs_count", fs_cnt, 3);
        check("b_fs_period", fs_gap, 176);

        // Hold at the last raster position: frozen, no strobes
        run_to(1, 15, 10, 400);
        ifb.en = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({ifb.sx, ifb.sy, ifb.de, ifb.line_start, ifb.frame_start} !== {10'd15, 10'd10, 3'b000})
                hold_err++;
        end
        check("b_hold", hold_err, 0);
        ifb.en = 1'b1;
        step();
        check("b_resume_pos", {ifb.sx, ifb.sy}, 20'd0);
        check("b_resume_fs", ifb.frame_start, 1);

        check("a_model", merr[0], 0);
        check("b_model", merr[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Pixel-clock video timing generator that drives the shader pipeline and TMDS encoders, upstream of both. Produces the raster coordinates sx/sy, the hsync/vsync/de signals, and line/frame strobes. It also produces copies of hsync/vsync/de delayed by a parameterised number of clocks, so that sync and blanking reach the encoders aligned with the colour data leaving the shader pipeline.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level (0 = active-low)
PIPE_DLY, 2, delay in clocks for *_d outputs; legal range 0..15

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  advance raster when high; hold when low
sx  out  10  horizontal position, 0..H_TOTAL-1
sy  out  10  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, aligned with sx/sy
vsync  out  1  vertical sync, aligned with sx/sy
de  out  1  data enable, aligned with sx/sy
line_start  out  1  one-clock pulse when sx becomes 0
frame_start  out  1  one-clock pulse when (sx,sy) becomes (0,0)
hsync_d  out  1  hsync delayed PIPE_DLY clocks
vsync_d  out  1  vsync delayed PIPE_DLY clocks
de_d  out  1  de delayed PIPE_DLY clocks
frame_cnt  out  16  frame counter (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* widths (800); V_TOTAL = sum of the V_* widths (525).
- Reset (async assert, sync release):
  - sx = H_TOTAL-1, sy = V_TOTAL-1.
  - de = 0; hsync = ~H_POL; vsync = ~V_POL.
  - line_start = 0, frame_start = 0, frame_cnt = 0.
  - Every delay-line stage resets to de = 0 and inactive sync levels.
- Reset mid-frame: immediately returns all outputs to the reset values. The raster restarts from the reset position.
- Counting, on each clk with en = 1:
  - sx increments; at H_TOTAL-1 it wraps to 0 and sy increments.
  - sy wraps from V_TOTAL-1 to 0 when sx wraps.
  - The first enabled clock after reset therefore lands on (0,0) with frame_start = 1.
- en = 0: sx, sy, hsync, vsync and de hold their values. line_start and frame_start are 0. The delay line keeps shifting.
- All outputs are registers. hsync/vsync/de are computed from the next-state counters, so they are valid in the same cycle as the sx/sy they describe:
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - hsync asserted (= H_POL) iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 with defaults.
  - vsync asserted (= V_POL) iff V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491 with defaults. vsync changes on the clock where sx becomes 0.
- Strobes:
  - line_start = 1 for exactly the one clock in which sx == 0 after an enabled advance.
  - frame_start = line_start && sy == 0.
  - No strobe is produced while the raster is held by en = 0.
- Delay line:
  - *_d equals the corresponding output sampled PIPE_DLY clocks earlier.
  - It shifts every clock, independent of en.
  - PIPE_DLY = 0: *_d are combinational copies of hsync/vsync/de.
- Width rules: H_TOTAL and V_TOTAL must be <= 1024. Elaboration fails if either exceeds 1024 or if PIPE_DLY > 15.

Optional Feature:
Macro VTG_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 in the cycle frame_start is asserted, so the count is visible one clock after the pulse. It wraps 65535 -> 0 and resets to 0.
- Undefined: no counter logic is built and frame_cnt is tied to 16'd0.

Test Plan:
- Reset release with en = 1 held -> first clock gives sx = 0, sy = 0, de = 1, frame_start = 1, line_start = 1; sx = 639 is the last cycle with de = 1 on line 0, and de = 0 from sx = 640.
- Free run one line -> hsync = 0 exactly for sx = 656..751 (96 clocks); line_start pulses every 800 clocks.
- Free run two frames -> vsync = 0 exactly for sy = 490..491 (1600 clocks); frame_start period is 420000 clocks; frame_cnt reads 1, then 2 (VTG_FRAME_CNT_EN defined), and stays 0 when undefined.
- Drop en for 5 clocks at sx = 799, sy = 524 -> sx/sy/de frozen and no strobes; first clock after en returns gives (0,0) with frame_start = 1.
- PIPE_DLY = 2 -> de_d, hsync_d and vsync_d match de/hsync/vsync shifted exactly 2 clocks; repeat with PIPE_DLY = 0 -> identical to the undelayed signals.
- Assert rst_n = 0 at sx = 300, sy = 100 -> outputs return to reset values immediately (de = 0, hsync = vsync = 1, *_d = inactive); after release the raster restarts at (0,0).
